// File: rtl/contador_param.sv
// contador_param: WIDTH-bit up/down/step/load counter with rco and saturating wrap count; CONTADOR_CASCADE_EN adds rci
module contador_param #(
    parameter int WIDTH = 8,
    parameter int STEP  = 3,
    parameter int WRAPW = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enable,
`ifdef CONTADOR_CASCADE_EN
    input  logic             rci,
`endif
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic [WRAPW-1:0] wrap_cnt,
    output logic             load_done
);
    typedef enum logic {RUN, LOADED} state_t;
    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STP  = (WIDTH+1)'(STEP);
    localparam logic [WRAPW-1:0] WMAX = '1;
    state_t state;
    logic cnt_en;
    logic [WIDTH:0] nxt;
`ifdef CONTADOR_CASCADE_EN
    assign cnt_en = enable && rci;
`else
    assign cnt_en = enable;
`endif
    // msb of the WIDTH+1 bit result is the carry (up/step) or borrow (down)
    always_comb nxt = modo == 2'b01 ? {1'b0, Q} - ONE : {1'b0, Q} + (modo == 2'b10 ? STP : ONE);
    assign load_done = state == LOADED;
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            Q        <= '0;
            rco      <= 1'b0;
            wrap_cnt <= '0;
            state    <= RUN;
        end else begin
            rco   <= 1'b0;
            state <= RUN;
            if (enable && modo == 2'b11) begin
                Q        <= D;
                wrap_cnt <= '0;
                state    <= LOADED;
            end else begin
                if (enable && rco && wrap_cnt != WMAX) wrap_cnt <= wrap_cnt + 1'b1;
                if (cnt_en) begin
                    Q   <= nxt[WIDTH-1:0];
                    rco <= nxt[WIDTH];
                end
            end
        end
    end
endmodule
